// File: rtl/riscv_pkg.sv
// Shared RISC-V memory-bus types: access size, data-port FSM states and the NOP
// returned for faulting or reset fetches.
package riscv_pkg;

  typedef enum logic [1:0] {
    MASK_B = 2'd0,
    MASK_H = 2'd1,
    MASK_X = 2'd2
  } MASK_SEL;

  typedef enum logic [1:0] {
    DM_IDLE = 2'd0,
    DM_WAIT = 2'd1,
    DM_RESP = 2'd2
  } DMEM_STATE;

  localparam logic [31:0] NOP_INST = 32'h0000_0013;

  function automatic logic access_misaligned(input MASK_SEL mask, input logic [1:0] offset);
    case (mask)
      MASK_H:  return offset[0];
      MASK_X:  return offset != 2'b00;
      default: return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/riscv_ram_load_ext.sv
// Load lane select and sign/zero extension; purely combinational so the LSU can
// reuse it on its own load path.
module riscv_ram_load_ext
  import riscv_pkg::*;
(
  input  logic [31:0] i_word,
  input  logic [1:0]  i_offset,
  input  MASK_SEL     i_mask,
  input  logic        i_unsigned,
  output logic [31:0] o_data
);

  logic [7:0]  w_byte;
  logic [15:0] w_half;

  always_comb begin
    case (i_offset)
      2'd0:    w_byte = i_word[7:0];
      2'd1:    w_byte = i_word[15:8];
      2'd2:    w_byte = i_word[23:16];
      default: w_byte = i_word[31:24];
    endcase
    w_half = i_offset[1] ? i_word[31:16] : i_word[15:0];
    case (i_mask)
      MASK_B:  o_data = {{24{w_byte[7] & ~i_unsigned}}, w_byte};
      MASK_H:  o_data = {{16{w_half[15] & ~i_unsigned}}, w_half};
      default: o_data = i_word;
    endcase
  end

endmodule

// File: rtl/riscv_ram_bus.sv
// Unified instruction/data RAM: registered fetch port plus a handshaked data port
// with byte-lane stores, extended loads, fault reporting and programmable latency.
module riscv_ram_bus
  import riscv_pkg::*;
#(
  parameter int WORD_LENGTH  = 32,
  parameter int NUM_WORDS    = 4096,
  parameter int DATA_LATENCY = 1
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic [WORD_LENGTH-1:0] i_addr,
  output logic [WORD_LENGTH-1:0] i_inst,
  output logic                   i_fault,
  input  logic                   d_req,
  output logic                   d_ready,
  input  logic                   d_we,
  input  logic [WORD_LENGTH-1:0] d_addr,
  input  logic [WORD_LENGTH-1:0] d_wdata,
  input  MASK_SEL                d_mask,
  input  logic                   d_unsigned,
  output logic                   d_rvalid,
  output logic [WORD_LENGTH-1:0] d_rdata,
  output logic                   d_err
);

  localparam int ADDR_W = $clog2(NUM_WORDS);
  localparam int IDX_HI = ADDR_W + 1;
  localparam bit LAT1 = (DATA_LATENCY == 1);
  localparam logic [1:0] CNT_INIT = (DATA_LATENCY > 1) ? 2'(DATA_LATENCY - 2) : 2'd0;

  logic [3:0][7:0] mem [NUM_WORDS];

  DMEM_STATE         r_state;
  logic [1:0]        r_cnt;
  logic              r_ready, r_rvalid, r_err, r_rdata_zero;
  logic [ADDR_W-1:0] r_idx;
  logic [1:0]        r_off, r_resp_off;
  MASK_SEL           r_mask, r_resp_mask;
  logic              r_uns, r_we, r_fault, r_resp_uns;
  logic [31:0]       r_rd_word, r_fetch_word;
  logic              r_fetch_nop, r_ifault;

  logic              w_accept, w_d_fault, w_i_fault, w_enter_resp;
  logic [ADDR_W-1:0] w_d_idx, w_i_idx, w_cur_idx;
  logic [1:0]        w_cur_off;
  MASK_SEL           w_cur_mask;
  logic              w_cur_uns, w_cur_we, w_cur_fault;
  logic [3:0]        w_be;
  logic [3:0][7:0]   w_wdata;
  logic [31:0]       w_load_ext;

  assign w_accept  = d_req & r_ready & ~rst;
  assign w_d_idx   = d_addr[IDX_HI:2];
  assign w_i_idx   = i_addr[IDX_HI:2];
  assign w_d_fault = access_misaligned(d_mask, d_addr[1:0]) | (|d_addr[WORD_LENGTH-1:ADDR_W+2]);
  assign w_i_fault = (i_addr[1:0] != 2'b00) | (|i_addr[WORD_LENGTH-1:ADDR_W+2]);

  // With single-cycle latency the RESP read happens on the accept edge itself,
  // so it must use the live request rather than the latched copy.
  assign w_enter_resp = LAT1 ? w_accept : (r_state == DM_WAIT && r_cnt == 2'd0);
  assign w_cur_idx    = LAT1 ? w_d_idx       : r_idx;
  assign w_cur_off    = LAT1 ? d_addr[1:0]   : r_off;
  assign w_cur_mask   = LAT1 ? d_mask        : r_mask;
  assign w_cur_uns    = LAT1 ? d_unsigned    : r_uns;
  assign w_cur_we     = LAT1 ? d_we          : r_we;
  assign w_cur_fault  = LAT1 ? w_d_fault     : r_fault;

  always_comb begin
    w_be    = 4'b0000;
    w_wdata = d_wdata;
    case (d_mask)
      MASK_B: begin
        w_be[d_addr[1:0]] = 1'b1;
        w_wdata = {4{d_wdata[7:0]}};
      end
      MASK_H: begin
        w_be    = d_addr[1] ? 4'b1100 : 4'b0011;
        w_wdata = {2{d_wdata[15:0]}};
      end
      default: w_be = 4'b1111;
    endcase
    if (!(w_accept && d_we && !w_d_fault)) w_be = 4'b0000;
  end

  // Reads sample the array before this edge's store lands (old-data collision).
  always_ff @(posedge clk) begin
    for (int b = 0; b < 4; b++) begin
      if (w_be[b]) mem[w_d_idx][b] <= w_wdata[b];
    end
    r_fetch_word <= mem[w_i_idx];
    if (w_enter_resp) r_rd_word <= mem[w_cur_idx];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_fetch_nop <= 1'b1;
      r_ifault    <= 1'b0;
    end else begin
      r_fetch_nop <= w_i_fault;
      r_ifault    <= w_i_fault;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state      <= DM_IDLE;
      r_cnt        <= 2'd0;
      r_ready      <= 1'b1;
      r_rvalid     <= 1'b0;
      r_err        <= 1'b0;
      r_rdata_zero <= 1'b1;
      r_idx        <= '0;
      r_off        <= 2'd0;
      r_mask       <= MASK_X;
      r_uns        <= 1'b0;
      r_we         <= 1'b0;
      r_fault      <= 1'b0;
      r_resp_off   <= 2'd0;
      r_resp_mask  <= MASK_X;
      r_resp_uns   <= 1'b0;
    end else begin
      if (w_accept) begin
        r_idx   <= w_d_idx;
        r_off   <= d_addr[1:0];
        r_mask  <= d_mask;
        r_uns   <= d_unsigned;
        r_we    <= d_we;
        r_fault <= w_d_fault;
      end
      if (w_enter_resp) begin
        r_err        <= w_cur_fault;
        r_rdata_zero <= w_cur_we | w_cur_fault;
        r_resp_off   <= w_cur_off;
        r_resp_mask  <= w_cur_mask;
        r_resp_uns   <= w_cur_uns;
      end
      case (r_state)
        DM_WAIT: begin
          if (r_cnt == 2'd0) begin
            r_state  <= DM_RESP;
            r_ready  <= 1'b1;
            r_rvalid <= 1'b1;
          end else begin
            r_cnt <= r_cnt - 2'd1;
          end
        end
        default: begin
          if (w_accept && LAT1) begin
            r_state  <= DM_RESP;
            r_ready  <= 1'b1;
            r_rvalid <= 1'b1;
          end else if (w_accept) begin
            r_state  <= DM_WAIT;
            r_cnt    <= CNT_INIT;
            r_ready  <= 1'b0;
            r_rvalid <= 1'b0;
          end else begin
            r_state  <= DM_IDLE;
            r_ready  <= 1'b1;
            r_rvalid <= 1'b0;
          end
        end
      endcase
    end
  end

  riscv_ram_load_ext u_load_ext (
    .i_word     (r_rd_word),
    .i_offset   (r_resp_off),
    .i_mask     (r_resp_mask),
    .i_unsigned (r_resp_uns),
    .o_data     (w_load_ext)
  );

  assign i_inst   = r_fetch_nop ? NOP_INST : r_fetch_word;
  assign i_fault  = r_ifault;
  assign d_ready  = r_ready;
  assign d_rvalid = r_rvalid;
  assign d_err    = r_err;
  assign d_rdata  = r_rdata_zero ? '0 : w_load_ext;

endmodule

// File: tb/tb_riscv_ram_bus.sv
// Scoreboard bench for riscv_ram_bus: three instances at latencies 1, 3 and 4
// driven by directed requests, with per-instance response monitors.
module tb_riscv_ram_bus;
  import riscv_pkg::*;

  localparam int NW = 4096;

  typedef struct {
    string       nm;
    logic [31:0] rdata;
    logic        err;
    int          cyc;
  } exp_t;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int n_checks = 0;
  int n_pass   = 0;

  logic        rst        [3];
  logic [31:0] i_addr     [3];
  logic [31:0] i_inst     [3];
  logic        i_fault    [3];
  logic        d_req      [3];
  logic        d_ready    [3];
  logic        d_we       [3];
  logic [31:0] d_addr     [3];
  logic [31:0] d_wdata    [3];
  MASK_SEL     d_mask     [3];
  logic        d_unsigned [3];
  logic        d_rvalid   [3];
  logic [31:0] d_rdata    [3];
  logic        d_err      [3];

  exp_t q0[$];
  exp_t q1[$];
  exp_t q2[$];

  function automatic int lat(input int idx);
    return (idx == 0) ? 1 : (idx == 1) ? 3 : 4;
  endfunction

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", nm, act, exp);
  endtask

  task automatic mon(input int idx);
    exp_t e;
    int   sz;
    sz = (idx == 0) ? q0.size() : (idx == 1) ? q1.size() : q2.size();
    if (sz == 0) begin
      n_checks++;
      $display("FAIL unexpected_rvalid dut%0d: got rvalid with rdata %h expected no response", idx, d_rdata[idx]);
      return;
    end
    case (idx)
      0:       e = q0.pop_front();
      1:       e = q1.pop_front();
      default: e = q2.pop_front();
    endcase
    chk({e.nm, "_rdata"}, d_rdata[idx], e.rdata);
    chk({e.nm, "_err"}, 32'(d_err[idx]), 32'(e.err));
    chk({e.nm, "_cycle"}, cyc, e.cyc);
    $display("dut%0d %s rdata=%h err=%0d cycle=%0d", idx, e.nm, d_rdata[idx], d_err[idx], cyc);
  endtask

  generate
    for (genvar gi = 0; gi < 3; gi++) begin : g_dut
      riscv_ram_bus #(
        .WORD_LENGTH  (32),
        .NUM_WORDS    (NW),
        .DATA_LATENCY ((gi == 0) ? 1 : (gi == 1) ? 3 : 4)
      ) u_dut (
        .clk        (clk),
        .rst        (rst[gi]),
        .i_addr     (i_addr[gi]),
        .i_inst     (i_inst[gi]),
        .i_fault    (i_fault[gi]),
        .d_req      (d_req[gi]),
        .d_ready    (d_ready[gi]),
        .d_we       (d_we[gi]),
        .d_addr     (d_addr[gi]),
        .d_wdata    (d_wdata[gi]),
        .d_mask     (d_mask[gi]),
        .d_unsigned (d_unsigned[gi]),
        .d_rvalid   (d_rvalid[gi]),
        .d_rdata    (d_rdata[gi]),
        .d_err      (d_err[gi])
      );

      always @(negedge clk) begin
        if (d_rvalid[gi]) mon(gi);
      end
    end
  endgenerate

  // Issues one request; on acceptance pushes the expected response with the
  // cycle in which d_rvalid must appear. Returns 1 time unit after the accept edge.
  task automatic req(input int idx, input string nm, input logic we, input logic [31:0] addr,
                     input logic [31:0] wdata, input MASK_SEL msk, input logic uns,
                     input logic [31:0] exp_rdata, input logic exp_err, input bit push);
    exp_t e;
    bit   done;
    done            = 1'b0;
    d_req[idx]      = 1'b1;
    d_we[idx]       = we;
    d_addr[idx]     = addr;
    d_wdata[idx]    = wdata;
    d_mask[idx]     = msk;
    d_unsigned[idx] = uns;
    for (int t = 0; t < 16 && !done; t++) begin
      if (d_ready[idx] === 1'b1) done = 1'b1;
      @(posedge clk);
      #1;
    end
    d_req[idx] = 1'b0;
    if (!done) begin
      n_checks++;
      $display("FAIL %s_accept: got no d_ready expected accept within 16 cycles", nm);
    end else if (push) begin
      e.nm    = nm;
      e.rdata = exp_rdata;
      e.err   = exp_err;
      e.cyc   = cyc + lat(idx) - 1;
      case (idx)
        0:       q0.push_back(e);
        1:       q1.push_back(e);
        default: q2.push_back(e);
      endcase
    end
  endtask

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_reset_vals(input int k, input string tag);
    chk($sformatf("%s_ready%0d", tag, k), 32'(d_ready[k]), 32'd1);
    chk($sformatf("%s_rvalid%0d", tag, k), 32'(d_rvalid[k]), 32'd0);
    chk($sformatf("%s_rdata%0d", tag, k), d_rdata[k], 32'd0);
    chk($sformatf("%s_err%0d", tag, k), 32'(d_err[k]), 32'd0);
    chk($sformatf("%s_inst%0d", tag, k), i_inst[k], 32'h0000_0013);
    chk($sformatf("%s_ifault%0d", tag, k), 32'(i_fault[k]), 32'd0);
  endtask

  initial begin
    int t_start;
    for (int k = 0; k < 3; k++) begin
      rst[k]        = 1'b1;
      i_addr[k]     = 32'h0;
      d_req[k]      = 1'b0;
      d_we[k]       = 1'b0;
      d_addr[k]     = 32'h0;
      d_wdata[k]    = 32'h0;
      d_mask[k]     = MASK_X;
      d_unsigned[k] = 1'b0;
    end
    idle(3);
    for (int k = 0; k < 3; k++) chk_reset_vals(k, "reset");
    for (int k = 0; k < 3; k++) rst[k] = 1'b0;
    idle(1);

    // Latency 1: sizes, extension and faults
    req(0, "sw_100",   1, 32'h100,  32'h0000_0000, MASK_X, 0, 32'h0000_0000, 0, 1);
    req(0, "sb_101",   1, 32'h101,  32'h0000_0080, MASK_B, 0, 32'h0000_0000, 0, 1);
    req(0, "lb_101",   0, 32'h101,  32'h0,         MASK_B, 0, 32'hFFFF_FF80, 0, 1);
    req(0, "lbu_101",  0, 32'h101,  32'h0,         MASK_B, 1, 32'h0000_0080, 0, 1);
    req(0, "lw_100",   0, 32'h100,  32'h0,         MASK_X, 0, 32'h0000_8000, 0, 1);
    req(0, "sh_103",   1, 32'h103,  32'h0000_1234, MASK_H, 0, 32'h0000_0000, 1, 1);
    req(0, "lw_100b",  0, 32'h100,  32'h0,         MASK_X, 0, 32'h0000_8000, 0, 1);
    req(0, "lw_oor",   0, NW * 4,   32'h0,         MASK_X, 0, 32'h0000_0000, 1, 1);
    req(0, "lw_102",   0, 32'h102,  32'h0,         MASK_X, 0, 32'h0000_0000, 1, 1);

    // Back-to-back with d_req held high; store then load of the same word
    t_start = cyc;
    req(0, "sw_200",   1, 32'h200,  32'hCAFE_F00D, MASK_X, 0, 32'h0000_0000, 0, 1);
    req(0, "lw_200",   0, 32'h200,  32'h0,         MASK_X, 0, 32'hCAFE_F00D, 0, 1);
    req(0, "sh_202",   1, 32'h202,  32'hFFFF_BEEF, MASK_H, 0, 32'h0000_0000, 0, 1);
    req(0, "lhu_202",  0, 32'h202,  32'h0,         MASK_H, 1, 32'h0000_BEEF, 0, 1);
    chk("b2b_cycles", cyc - t_start, 32'd4);
    req(0, "sb_203",   1, 32'h203,  32'hAABB_CC11, MASK_B, 0, 32'h0000_0000, 0, 1);
    req(0, "lw_200b",  0, 32'h200,  32'h0,         MASK_X, 0, 32'h11EF_F00D, 0, 1);
    req(0, "lb_200",   0, 32'h200,  32'h0,         MASK_B, 0, 32'h0000_000D, 0, 1);
    req(0, "lb_201",   0, 32'h201,  32'h0,         MASK_B, 0, 32'hFFFF_FFF0, 0, 1);
    req(0, "lh_200",   0, 32'h200,  32'h0,         MASK_H, 0, 32'hFFFF_F00D, 0, 1);
    req(0, "lh_202",   0, 32'h202,  32'h0,         MASK_H, 0, 32'h0000_11EF, 0, 1);
    idle(2);

    // Fetch port: same-edge collision, misaligned and out-of-range fetches
    req(0, "sw_40a",   1, 32'h40,   32'hA5A5_A5A5, MASK_X, 0, 32'h0000_0000, 0, 1);
    idle(2);
    i_addr[0] = 32'h40;
    req(0, "sw_40b",   1, 32'h40,   32'h1234_5678, MASK_X, 0, 32'h0000_0000, 0, 1);
    chk("fetch_old", i_inst[0], 32'hA5A5_A5A5);
    chk("fetch_old_fault", 32'(i_fault[0]), 32'd0);
    idle(1);
    chk("fetch_new", i_inst[0], 32'h1234_5678);
    i_addr[0] = 32'h42;
    idle(1);
    chk("fetch_mis_fault", 32'(i_fault[0]), 32'd1);
    chk("fetch_mis_inst", i_inst[0], 32'h0000_0013);
    i_addr[0] = NW * 4;
    idle(1);
    chk("fetch_oor_fault", 32'(i_fault[0]), 32'd1);
    chk("fetch_oor_inst", i_inst[0], 32'h0000_0013);
    i_addr[0] = 32'h100;
    idle(1);
    chk("fetch_100", i_inst[0], 32'h0000_8000);
    $display("dut0 fetch checks done at cycle %0d", cyc);

    // Latency 3: word round trip, d_ready low while waiting, data held after RESP
    req(1, "l3_sw_100", 1, 32'h100, 32'hDEAD_BEEF, MASK_X, 0, 32'h0000_0000, 0, 1);
    idle(4);
    req(1, "l3_lw_100", 0, 32'h100, 32'h0,         MASK_X, 0, 32'hDEAD_BEEF, 0, 1);
    chk("l3_ready_wait0", 32'(d_ready[1]), 32'd0);
    idle(1);
    chk("l3_ready_wait1", 32'(d_ready[1]), 32'd0);
    idle(4);
    chk("l3_rdata_hold", d_rdata[1], 32'hDEAD_BEEF);
    chk("l3_ready_idle", 32'(d_ready[1]), 32'd1);

    // Latency 4: reset two cycles after a load accept aborts it
    req(2, "l4_sw_10",  1, 32'h10,  32'h0000_0055, MASK_X, 0, 32'h0000_0000, 0, 1);
    idle(6);
    req(2, "l4_lw_10",  0, 32'h10,  32'h0,         MASK_X, 0, 32'h0000_0055, 0, 1);
    idle(6);
    chk("l4_rdata_hold", d_rdata[2], 32'h0000_0055);
    req(2, "l4_lw_abort", 0, 32'h10, 32'h0,        MASK_X, 0, 32'h0000_0000, 0, 0);
    idle(1);
    rst[2] = 1'b1;
    idle(1);
    chk_reset_vals(2, "l4_abort");
    rst[2] = 1'b0;
    idle(8);
    req(2, "l4_lw_after", 0, 32'h10, 32'h0,        MASK_X, 0, 32'h0000_0055, 0, 1);
    idle(6);

    chk("q0_drained", q0.size(), 32'd0);
    chk("q1_drained", q1.size(), 32'd0);
    chk("q2_drained", q2.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/riscv_ram_bus.md
# riscv_ram_bus

Parametrised, word-organised unified instruction/data memory for the RISC-V core. It adds a registered instruction fetch port and a handshaked data port with programmable read latency. The data port also provides byte-lane writes, load sign/zero extension, and misaligned/out-of-range fault reporting. It sits between the core's fetch/LSU stages and the on-chip RAM array and replaces the earlier combinational-read RAM.

## Interface
- `WORD_LENGTH`, 32: data/address width; only 32 is supported.
- `NUM_WORDS`, 4096: depth in 32-bit words; must be a power of two. Byte address space is `NUM_WORDS*4`.
- `DATA_LATENCY`, 1: cycles from data-request acceptance to response; legal range 1..4.
- `clk`  in  1  clock.
- `rst`  in  1  synchronous, active-high reset.
- `i_addr`  in  32  fetch byte address, sampled every cycle.
- `i_inst`  out  32  instruction for the `i_addr` of the previous cycle.
- `i_fault`  out  1  previous fetch was misaligned (`i_addr[1:0]!=0`) or out of range.
- `d_req`  in  1  data request valid.
- `d_ready`  out  1  data port can accept a request this cycle.
- `d_we`  in  1  1 = store, 0 = load.
- `d_addr`  in  32  data byte address.
- `d_wdata`  in  32  store data; least-significant bytes are used for B/H.
- `d_mask`  in  `MASK_SEL`  access size: `MASK_B`, `MASK_H`, `MASK_X` (word).
- `d_unsigned`  in  1  selects zero extension for B/H loads.
- `d_rvalid`  out  1  one-cycle response strobe, issued for loads and stores.
- `d_rdata`  out  32  extended load data; 0 for stores and faults.
- `d_err`  out  1  accompanies `d_rvalid`; the access was misaligned or out of range.

## Operation
- The request is accepted when `d_req && d_ready`. Address, size, `d_we` and `d_unsigned` are latched at acceptance.
- Fault check at acceptance:
  - H requires `d_addr[0]==0`.
  - X requires `d_addr[1:0]==0`.
  - Any access with `d_addr >= NUM_WORDS*4` faults.
  - A faulting store writes nothing.
- Store commit happens at the acceptance edge.
  - B writes lane `d_addr[1:0]`; H writes lanes {`d_addr[1]*2`, +1}; X writes all four lanes.
  - Unwritten lanes are unchanged.
- Load data is read from the array at the edge entering RESP.
  - The selected lane(s) are shifted to bit 0, then sign-extended, or zero-extended if `d_unsigned`. X loads are passed through.
- FSM `DMEM_STATE`, which is held in IDLE by reset:
  - IDLE: `d_ready=1`. On accept, go to RESP if `DATA_LATENCY==1`; otherwise go to WAIT and load the counter with `DATA_LATENCY-2`.
  - WAIT: `d_ready=0`. Decrement the counter; go to RESP when it is 0.
  - RESP: `d_rvalid=1` for exactly one cycle and `d_ready=1`. An accept here chains directly (to WAIT or RESP as from IDLE); otherwise go to IDLE.
- Fetch port: the word at `i_addr[..:2]` is registered into `i_inst` every cycle; no stall input.
- Read/write collision:
  - A fetch or load read on the same edge as a store commit to the same word returns the old data.
  - A load accepted after a store always sees the stored data.
- Memory contents are not reset.

## Timing
- Reset values: `d_ready=1`, `d_rvalid=0`, `d_rdata=0`, `d_err=0`, `i_inst=32'h0000_0013` (NOP), `i_fault=0`, state IDLE, counter 0.
- Reset mid-transaction aborts it:
  - A store already committed stays committed.
  - No `d_rvalid` is produced for the aborted request.
- Data latency: accept on edge N produces `d_rvalid` high during the cycle after edge N+`DATA_LATENCY-1`, i.e. `DATA_LATENCY` cycles after acceptance.
- Throughput is one request per `DATA_LATENCY` cycles (back-to-back through RESP).
- Fetch latency is fixed at 1 cycle. `i_fault` is aligned with `i_inst`; a faulting fetch returns `i_inst=32'h0000_0013`.
- `d_rdata` and `d_err` hold their values until the next RESP or reset. They are meaningful only with `d_rvalid`.

## Structure
- `riscv_pkg` holds:
  - `MASK_SEL` (`MASK_B`, `MASK_H`, `MASK_X`), shared with the LSU.
  - The `DMEM_STATE` enum (`DM_IDLE`, `DM_WAIT`, `DM_RESP`).
  - The constant `NOP_INST = 32'h0000_0013`.
- Sub-module `riscv_ram_load_ext`: a combinational lane-select and sign/zero-extend block, reusable by the LSU.
- The array is `logic [3:0][7:0] mem[NUM_WORDS]`, with per-lane write enables.

## Test plan
- Word round trip: store X `0xDEADBEEF` to `0x100`, then load X `0x100` with `DATA_LATENCY=3` -> `d_rvalid` 3 cycles after accept, `d_rdata=0xDEADBEEF`, `d_err=0`.
- Byte store and extension: store B `0x80` to `0x101` over `0x00000000`, then:
  - LB `0x101` -> `0xFFFFFF80`.
  - LBU `0x101` -> `0x00000080`.
  - LW `0x100` -> `0x00008000`.
- Faults:
  - Store H to `0x103` -> `d_err=1`, `d_rdata=0`, memory unchanged.
  - Load X at `NUM_WORDS*4` -> `d_err=1`.
- Back-to-back with `DATA_LATENCY=1`: `d_req` held high for 4 requests -> one `d_rvalid` per cycle. A store followed immediately by a load to the same word returns the new data.
- Fetch collision: store `0x12345678` to `0x40` while `i_addr=0x40` on the same edge -> `i_inst` shows old data, then `0x12345678` one cycle later. `i_addr=0x42` -> `i_fault=1`, `i_inst=0x00000013`.
- Reset during WAIT (`DATA_LATENCY=4`, `rst` asserted 2 cycles after a load accept) -> no `d_rvalid`; all outputs at reset values the next cycle; `d_ready=1`.
